mem_wr_ctrl: RTL
================

Name: mem_wr_ctrl

Overview:
- Ingress stage directly upstream of the FFT transpose memory bank.
- Accepts the 512-bit AXI-Stream sample stream (8 lanes × 64 b) and drives the bank's port-A write interface: wea, addra, dina0..dina7.
- Counts a full LENGTH×LENGTH frame, issues a one-cycle flag0 pulse so the bank swaps state, then stalls the stream until the downstream FFT stage signals release.

Parameters:
- LENGTH, 64: FFT points per dimension; a frame is LENGTH*LENGTH beats.
- SIZE_GROUP, 8: lanes per beat. Fixed at 8 by the dina0..7 port list.
- DWIDTH_BRAM, 64: bits per lane.
- AWIDTH_BRAM, 12: address width. Must satisfy 2^AWIDTH_BRAM >= LENGTH*LENGTH.

Ports:
- sclk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- s_tdata  in  SIZE_GROUP*DWIDTH_BRAM  stream data; lane i = bits [64i+63:64i].
- s_tkeep  in  SIZE_GROUP*DWIDTH_BRAM/8  byte enables.
- s_tvalid  in  1  stream valid.
- s_tlast  in  1  end-of-frame marker from the source.
- s_tready  out  1  stream ready.
- release_i  in  1  one-cycle pulse from downstream: bank consumed, next frame may be written.
- wea  out  SIZE_GROUP  per-lane write enable to the bank.
- addra  out  AWIDTH_BRAM  write address.
- dina0..dina7  out  DWIDTH_BRAM each  lane write data.
- flag0  out  1  frame-complete pulse to the bank.
- busy  out  1  high in FLAG or HOLD.
- frame_cnt  out  16  completed frames, wraps at 0xFFFF.
- err_tlast  out  1  sticky tlast-mismatch flag.

Behaviour:
- **Reset (async, rst_n low)**
  - All outputs 0, except s_tready = 0 for the reset cycle and the first cycle after release.
  - State = FILL, beat counter cnt = 0, release latch = 0.
  - Reset mid-frame discards the partial frame; no flag0 is issued.
- **State FILL**
  - s_tready = 1. A handshake is tvalid & tready.
  - On each handshake, next cycle: addra = cnt, dina_i = lane i of s_tdata, wea[i] = &s_tkeep[8i+7:8i].
  - wea = 0 on cycles with no handshake. addra and dina hold their last value when idle.
  - cnt increments per handshake.
  - A handshake with cnt == LENGTH*LENGTH-1 moves to FLAG, and s_tready drops in the same cycle's registered update, so no further beat is accepted.
- **State FLAG**
  - Lasts one cycle. flag0 = 1, s_tready = 0, wea = 0.
  - flag0 is therefore asserted exactly 2 cycles after the final handshake edge (1 cycle after the final wea).
  - frame_cnt increments. cnt resets to 0. Go to HOLD.
- **State HOLD**
  - s_tready = 0, busy = 1.
  - Leave to FILL on release_i, or on a release latched earlier.
  - release_i seen in FILL (late ack of a previous frame) or FLAG is latched; HOLD then exits after one cycle.
  - Multiple release pulses before HOLD collapse to one.
- **s_tready** is registered (no combinational path from s_tvalid).
- **Latency:** handshake → wea/addra/dina = 1 cycle.
- **Address:** row-major, addra = beat index, 0..LENGTH*LENGTH-1. No wrap occurs inside a frame.
- **tlast check**
  - err_tlast sets (sticky until reset) when tlast = 1 on a non-final beat, or tlast = 0 on the final beat.
  - Addressing is unaffected; the frame is always exactly LENGTH*LENGTH beats.
- **Partial tkeep:** masked lanes are not written; the counter still advances.

Test Plan:
- **Full frame, LENGTH=4 (16 beats), continuous tvalid, tlast on beat 15**
  - Required: addra 0..15 on consecutive cycles, wea = 0xFF each beat.
  - Required: flag0 high for one cycle, 1 cycle after the addra = 15 write.
  - Required: s_tready low from then on; frame_cnt = 1; err_tlast = 0.
- **Backpressure release**
  - Hold 5 cycles after flag0, then pulse release_i.
  - Required: s_tready rises the cycle after release; next beat writes addra = 0.
- **Early release**
  - Pulse release_i during beat 7 of frame 2.
  - Required: HOLD lasts exactly 1 cycle after flag0; s_tready returns without further release.
- **Bad tlast, LENGTH=4**
  - tlast on beat 9, then again on beat 15.
  - Required: err_tlast = 1 after beat 9; flag0 still after beat 15; addresses 0..15.
- **Lane mask**
  - s_tkeep = 0x00FF_FFFF_FFFF_FFFF on beat 3.
  - Required: wea = 0x7F at addra = 3.
- **Reset mid-frame**
  - Assert rst_n low after beat 6.
  - Required: all outputs 0, no flag0; after reset, the next beat writes addra = 0.

Source files
------------

// File: rtl/mem_wr_ctrl.sv
// mem_wr_ctrl: ingress write controller for the FFT transpose memory bank.
// Takes a SIZE_GROUP-lane AXI-Stream sample stream and writes one beat per
// handshake into the bank's port A. The address is the beat index, so a
// frame lands row-major. After LENGTH*LENGTH beats the block pulses flag0
// so the bank swaps halves. It then holds off the stream until downstream
// signals release_i.
//
// Ports:
//   sclk, rst_n        clock, asynchronous active-low reset
//   s_tdata/s_tkeep    stream payload and byte enables (lane i = bits [64i+63:64i])
//   s_tvalid/s_tlast   stream valid and source end-of-frame marker
//   s_tready           registered stream ready
//   release_i          downstream pulse: bank consumed, next frame may be written
//   wea/addra/dina0..7 bank port-A write (per-lane enable, address, lane data)
//   flag0              one-cycle frame-complete pulse to the bank
//   busy               frame complete and waiting for release
//   frame_cnt          completed frames, wraps at 0xFFFF
//   err_tlast          sticky: s_tlast disagreed with the beat count
module mem_wr_ctrl #(
  parameter int unsigned LENGTH      = 64,
  parameter int unsigned SIZE_GROUP  = 8,
  parameter int unsigned DWIDTH_BRAM = 64,
  parameter int unsigned AWIDTH_BRAM = 12
) (
  input  logic                                sclk,
  input  logic                                rst_n,
  input  logic [SIZE_GROUP*DWIDTH_BRAM-1:0]   s_tdata,
  input  logic [SIZE_GROUP*DWIDTH_BRAM/8-1:0] s_tkeep,
  input  logic                                s_tvalid,
  input  logic                                s_tlast,
  output logic                                s_tready,
  input  logic                                release_i,
  output logic [SIZE_GROUP-1:0]               wea,
  output logic [AWIDTH_BRAM-1:0]              addra,
  output logic [DWIDTH_BRAM-1:0]              dina0,
  output logic [DWIDTH_BRAM-1:0]              dina1,
  output logic [DWIDTH_BRAM-1:0]              dina2,
  output logic [DWIDTH_BRAM-1:0]              dina3,
  output logic [DWIDTH_BRAM-1:0]              dina4,
  output logic [DWIDTH_BRAM-1:0]              dina5,
  output logic [DWIDTH_BRAM-1:0]              dina6,
  output logic [DWIDTH_BRAM-1:0]              dina7,
  output logic                                flag0,
  output logic                                busy,
  output logic [15:0]                         frame_cnt,
  output logic                                err_tlast
);

  localparam int unsigned DATA_W      = SIZE_GROUP * DWIDTH_BRAM;
  localparam int unsigned LANE_BYTES  = DWIDTH_BRAM / 8;
  localparam int unsigned FRAME_BEATS = LENGTH * LENGTH;
  localparam logic [AWIDTH_BRAM-1:0] LAST_BEAT = AWIDTH_BRAM'(FRAME_BEATS - 1);

  typedef enum logic [1:0] {
    ST_FILL = 2'd0,
    ST_FLAG = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  state_t                   state_q, state_d;
  logic [AWIDTH_BRAM-1:0]   cnt_q, cnt_d;
  logic                     rel_q, rel_d;
  logic                     tready_q, tready_d;
  logic [SIZE_GROUP-1:0]    wea_q, wea_d;
  logic [AWIDTH_BRAM-1:0]   addra_q, addra_d;
  logic [DATA_W-1:0]        dina_q, dina_d;
  logic                     flag0_q, flag0_d;
  logic                     busy_q, busy_d;
  logic [15:0]              frame_cnt_q, frame_cnt_d;
  logic                     err_q, err_d;

  logic                     hs;
  logic                     last_beat;
  logic [SIZE_GROUP-1:0]    lane_full;

  // A lane is written only when all of its byte enables are set.
  for (genvar g = 0; g < SIZE_GROUP; g++) begin : g_lane
    assign lane_full[g] = &s_tkeep[g*LANE_BYTES +: LANE_BYTES];
  end

  assign hs        = s_tvalid & tready_q;
  assign last_beat = (cnt_q == LAST_BEAT);

  // State and output registers.
  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_FILL;
      cnt_q       <= '0;
      rel_q       <= 1'b0;
      tready_q    <= 1'b0;
      wea_q       <= '0;
      addra_q     <= '0;
      dina_q      <= '0;
      flag0_q     <= 1'b0;
      busy_q      <= 1'b0;
      frame_cnt_q <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rel_q       <= rel_d;
      tready_q    <= tready_d;
      wea_q       <= wea_d;
      addra_q     <= addra_d;
      dina_q      <= dina_d;
      flag0_q     <= flag0_d;
      busy_q      <= busy_d;
      frame_cnt_q <= frame_cnt_d;
      err_q       <= err_d;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rel_d       = rel_q;
    tready_d    = tready_q;
    wea_d       = '0;
    addra_d     = addra_q;
    dina_d      = dina_q;
    flag0_d     = 1'b0;
    frame_cnt_d = frame_cnt_q;
    err_d       = err_q;

    case (state_q)
      ST_FILL: begin
        tready_d = 1'b1;
        // A late ack for the previous frame is remembered for the next HOLD.
        if (release_i) rel_d = 1'b1;
        if (hs) begin
          wea_d   = lane_full;
          addra_d = cnt_q;
          dina_d  = s_tdata;
          if (s_tlast != last_beat) err_d = 1'b1;
          cnt_d = cnt_q + AWIDTH_BRAM'(1);
          if (last_beat) begin
            // Drop ready on the same edge so no beat of the next frame slips in.
            state_d  = ST_FLAG;
            tready_d = 1'b0;
          end
        end
      end
      ST_FLAG: begin
        tready_d    = 1'b0;
        flag0_d     = 1'b1;
        frame_cnt_d = frame_cnt_q + 16'd1;
        cnt_d       = '0;
        state_d     = ST_HOLD;
        if (release_i) rel_d = 1'b1;
      end
      ST_HOLD: begin
        tready_d = 1'b0;
        if (release_i || rel_q) begin
          state_d  = ST_FILL;
          tready_d = 1'b1;
          rel_d    = 1'b0;
        end
      end
      default: begin
        state_d  = ST_FILL;
        tready_d = 1'b0;
      end
    endcase

    busy_d = (state_d != ST_FILL);
  end

  assign s_tready  = tready_q;
  assign wea       = wea_q;
  assign addra     = addra_q;
  assign flag0     = flag0_q;
  assign busy      = busy_q;
  assign frame_cnt = frame_cnt_q;
  assign err_tlast = err_q;

  assign dina0 = dina_q[0*DWIDTH_BRAM +: DWIDTH_BRAM];
  assign dina1 = dina_q[1*DWIDTH_BRAM +: DWIDTH_BRAM];
  assign dina2 = dina_q[2*DWIDTH_BRAM +: DWIDTH_BRAM];
  assign dina3 = dina_q[3*DWIDTH_BRAM +: DWIDTH_BRAM];
  assign dina4 = dina_q[4*DWIDTH_BRAM +: DWIDTH_BRAM];
  assign dina5 = dina_q[5*DWIDTH_BRAM +: DWIDTH_BRAM];
  assign dina6 = dina_q[6*DWIDTH_BRAM +: DWIDTH_BRAM];
  assign dina7 = dina_q[7*DWIDTH_BRAM +: DWIDTH_BRAM];

endmodule
